// File: rtl/id_stage_q_pkg.sv
// Shared decode definitions for the queued RV32I(+M) decode stage:
// opcodes, operation codes, the queue entry and the registered bundle.
package id_stage_q_pkg;

   localparam int OPT_W = 6;

   localparam logic [6:0] OPCODE_NOP    = 7'b0000000;
   localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
   localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
   localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
   localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
   localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
   localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
   localparam logic [6:0] OPCODE_CALCI  = 7'b0010011;
   localparam logic [6:0] OPCODE_CALC   = 7'b0110011;

   localparam logic [4:0] NOP_REG_ADDR = 5'd0;

   // ADD..AND and MUL..REMU are ordered by funct3 so decode can offset into them.
   typedef enum logic [OPT_W-1:0] {
      OPT_NOP, OPT_LUI, OPT_AUIPC, OPT_JAL, OPT_JALR,
      OPT_BEQ, OPT_BNE, OPT_BLT, OPT_BGE, OPT_BLTU, OPT_BGEU,
      OPT_LB, OPT_LH, OPT_LW, OPT_LBU, OPT_LHU,
      OPT_SB, OPT_SH, OPT_SW,
      OPT_ADDI, OPT_SLTI, OPT_SLTIU, OPT_XORI, OPT_ORI, OPT_ANDI,
      OPT_SLLI, OPT_SRLI, OPT_SRAI,
      OPT_ADD, OPT_SLL, OPT_SLT, OPT_SLTU, OPT_XOR, OPT_SRL, OPT_OR, OPT_AND,
      OPT_SUB, OPT_SRA,
      OPT_MUL, OPT_MULH, OPT_MULHSU, OPT_MULHU, OPT_DIV, OPT_DIVU, OPT_REM, OPT_REMU
   } opt_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } iq_entry_t;

   typedef struct packed {
      logic [6:0]  opcode;
      opt_e        opt;
      logic        re1;
      logic        re2;
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] imm;
      logic [4:0]  shamt;
      logic        illegal;
   } dec_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [6:0]  opcode;
      opt_e        opt;
      logic [31:0] rdata1;
      logic [31:0] rdata2;
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] imm;
      logic [4:0]  shamt;
      logic        illegal;
   } bundle_t;

   function automatic logic [31:0] sext12(input logic [11:0] v);
      return {{20{v[11]}}, v};
   endfunction

endpackage

// File: rtl/id_stage_q_queue.sv
// Synchronous {pc,inst} FIFO in front of the decoder; flush and reset empty it.
module id_inst_queue
   import id_stage_q_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  iq_entry_t                data_i,
   output iq_entry_t                head_o,
   output logic [$clog2(DEPTH):0]   count_o
);
   localparam int AW = $clog2(DEPTH);

   iq_entry_t      mem_q [DEPTH];
   logic [AW-1:0]  rd_ptr_q, wr_ptr_q;
   logic [AW:0]    count_q;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_q + {{AW{1'b0}}, push_i} - {{AW{1'b0}}, pop_i};
      end
   end

   always_ff @(posedge clk) begin
      if (push_i && !flush_i && !rst) mem_q[wr_ptr_q] <= data_i;
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/id_stage_q.sv
// Queued RV32I(+M) decode stage: buffers fetched words, decodes the queue head,
// reads the regfile and registers the decode bundle toward ex.
module id_stage_q
   import id_stage_q_pkg::*;
#(
   parameter int IQ_DEPTH = 4,
   parameter bit ENABLE_M = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [31:0]      in_pc_i,
   input  logic [31:0]      in_inst_i,
   output logic             re1_o,
   output logic             re2_o,
   output logic [4:0]       raddr1_o,
   output logic [4:0]       raddr2_o,
   input  logic [31:0]      rdata1_i,
   input  logic [31:0]      rdata2_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [31:0]      pc_o,
   output logic [6:0]       opcode_o,
   output logic [OPT_W-1:0] opt_o,
   output logic [31:0]      rdata1_o,
   output logic [31:0]      rdata2_o,
   output logic             we_o,
   output logic [4:0]       waddr_o,
   output logic [31:0]      imm_o,
   output logic [4:0]       shamt_o,
   output logic             illegal_o
);
   localparam int CW = $clog2(IQ_DEPTH) + 1;

   iq_entry_t       head;
   logic [CW-1:0]   count;
   logic            head_valid, push, adv;
   dec_t            dec;
   bundle_t         bundle_q, bundle_d;
   logic            out_valid_q, out_valid_d;

   function automatic dec_t decode(input logic [31:0] inst);
      dec_t       d;
      logic [2:0] f3;
      logic [6:0] f7;
      logic       wr, bad;
      f3 = inst[14:12];
      f7 = inst[31:25];
      d = '0;
      d.opcode = inst[6:0];
      wr  = 1'b0;
      bad = 1'b0;
      case (inst[6:0])
         OPCODE_LUI:   begin d.opt = OPT_LUI;   d.imm = {inst[31:12], 12'b0}; wr = 1'b1; end
         OPCODE_AUIPC: begin d.opt = OPT_AUIPC; d.imm = {inst[31:12], 12'b0}; wr = 1'b1; end
         OPCODE_JAL: begin
            d.opt = OPT_JAL;
            d.imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
            wr = 1'b1;
         end
         OPCODE_JALR: begin
            d.opt = OPT_JALR; d.imm = sext12(inst[31:20]); d.re1 = 1'b1; wr = 1'b1;
            bad = (f3 != 3'd0);
         end
         OPCODE_BRANCH: begin
            d.re1 = 1'b1; d.re2 = 1'b1;
            d.imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
            case (f3)
               3'd0: d.opt = OPT_BEQ;   3'd1: d.opt = OPT_BNE;
               3'd4: d.opt = OPT_BLT;   3'd5: d.opt = OPT_BGE;
               3'd6: d.opt = OPT_BLTU;  3'd7: d.opt = OPT_BGEU;
               default: bad = 1'b1;
            endcase
         end
         OPCODE_LOAD: begin
            d.re1 = 1'b1; d.imm = sext12(inst[31:20]); wr = 1'b1;
            case (f3)
               3'd0: d.opt = OPT_LB;  3'd1: d.opt = OPT_LH;  3'd2: d.opt = OPT_LW;
               3'd4: d.opt = OPT_LBU; 3'd5: d.opt = OPT_LHU;
               default: bad = 1'b1;
            endcase
         end
         OPCODE_STORE: begin
            d.re1 = 1'b1; d.re2 = 1'b1; d.imm = sext12({inst[31:25], inst[11:7]});
            case (f3)
               3'd0: d.opt = OPT_SB; 3'd1: d.opt = OPT_SH; 3'd2: d.opt = OPT_SW;
               default: bad = 1'b1;
            endcase
         end
         OPCODE_CALCI: begin
            d.re1 = 1'b1; d.imm = sext12(inst[31:20]); wr = 1'b1;
            case (f3)
               3'd0: d.opt = OPT_ADDI;  3'd2: d.opt = OPT_SLTI;
               3'd3: d.opt = OPT_SLTIU; 3'd4: d.opt = OPT_XORI;
               3'd6: d.opt = OPT_ORI;   3'd7: d.opt = OPT_ANDI;
               default: begin
                  // Shift-immediate: operand is shamt, not imm.
                  d.imm = '0; d.shamt = inst[24:20];
                  if (f3 == 3'd1 && f7 == 7'b0000000)      d.opt = OPT_SLLI;
                  else if (f3 == 3'd5 && f7 == 7'b0000000) d.opt = OPT_SRLI;
                  else if (f3 == 3'd5 && f7 == 7'b0100000) d.opt = OPT_SRAI;
                  else bad = 1'b1;
               end
            endcase
         end
         OPCODE_CALC: begin
            d.re1 = 1'b1; d.re2 = 1'b1; wr = 1'b1;
            if (f7 == 7'b0000000)                    d.opt = opt_e'(OPT_W'(OPT_ADD) + OPT_W'(f3));
            else if (f7 == 7'b0100000 && f3 == 3'd0) d.opt = OPT_SUB;
            else if (f7 == 7'b0100000 && f3 == 3'd5) d.opt = OPT_SRA;
            else if (f7 == 7'b0000001 && ENABLE_M)   d.opt = opt_e'(OPT_W'(OPT_MUL) + OPT_W'(f3));
            else bad = 1'b1;
         end
         default: bad = 1'b1;
      endcase
      if (bad) begin
         d = '0;
         d.illegal = 1'b1;
      end else begin
         d.we    = wr && (inst[11:7] != 5'd0);
         d.waddr = wr ? inst[11:7] : NOP_REG_ADDR;
      end
      return d;
   endfunction

   id_inst_queue #(.DEPTH(IQ_DEPTH)) u_iq (
      .clk     (clk),
      .rst     (rst),
      .flush_i (flush_i),
      .push_i  (push),
      .pop_i   (adv),
      .data_i  ({in_pc_i, in_inst_i}),
      .head_o  (head),
      .count_o (count)
   );

   assign head_valid = (count != '0);
   assign in_ready_o = !rst && (count < CW'(IQ_DEPTH));
   assign push       = in_valid_i && in_ready_o && !flush_i;
   assign adv        = head_valid && (!out_valid_q || out_ready_i) && !flush_i;
   assign dec        = head_valid ? decode(head.inst) : '0;

   assign re1_o    = dec.re1;
   assign re2_o    = dec.re2;
   assign raddr1_o = head_valid ? head.inst[19:15] : NOP_REG_ADDR;
   assign raddr2_o = head_valid ? head.inst[24:20] : NOP_REG_ADDR;

   always_comb begin
      bundle_d    = bundle_q;
      out_valid_d = out_valid_q;
      if (flush_i) begin
         out_valid_d = 1'b0;
      end else if (adv) begin
         bundle_d.pc      = head.pc;
         bundle_d.opcode  = dec.opcode;
         bundle_d.opt     = dec.opt;
         bundle_d.rdata1  = rdata1_i;
         bundle_d.rdata2  = rdata2_i;
         bundle_d.we      = dec.we;
         bundle_d.waddr   = dec.waddr;
         bundle_d.imm     = dec.imm;
         bundle_d.shamt   = dec.shamt;
         bundle_d.illegal = dec.illegal;
         out_valid_d      = 1'b1;
      end else if (out_valid_q && out_ready_i) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bundle_q    <= '0;
         out_valid_q <= 1'b0;
      end else begin
         bundle_q    <= bundle_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_valid_o = out_valid_q;
   assign pc_o        = bundle_q.pc;
   assign opcode_o    = bundle_q.opcode;
   assign opt_o       = bundle_q.opt;
   assign rdata1_o    = bundle_q.rdata1;
   assign rdata2_o    = bundle_q.rdata2;
   assign we_o        = bundle_q.we;
   assign waddr_o     = bundle_q.waddr;
   assign imm_o       = bundle_q.imm;
   assign shamt_o     = bundle_q.shamt;
   assign illegal_o   = bundle_q.illegal;

endmodule

// File: tb/tb_id_stage_q.sv
// Bench for id_stage_q: two instances (M off / M on) share stimulus and are
// checked every cycle against a mask/match decode table plus a queue model.
module tb_id_stage_q;
   import id_stage_q_pkg::*;

   localparam int D  = 4;
   localparam int NT = 45;
   localparam logic [31:0] MU = 32'h0000007f;
   localparam logic [31:0] MI = 32'h0000707f;
   localparam logic [31:0] MR = 32'hfe00707f;

   typedef enum logic [2:0] {F_U, F_J, F_I, F_B, F_S, F_R, F_SH} fmt_e;
   typedef struct {
      logic [31:0] match;
      logic [31:0] mask;
      opt_e        opt;
      fmt_e        fmt;
   } row_t;

   typedef struct packed {
      logic irdy; logic ov; logic re1; logic re2;
      logic [4:0] ra1; logic [4:0] ra2;
      logic [31:0] pc; logic [6:0] opc; logic [OPT_W-1:0] opt;
      logic [31:0] rd1; logic [31:0] rd2;
      logic we; logic [4:0] wa; logic [31:0] imm; logic [4:0] sh; logic ill;
   } obs_t;

   row_t tbl [NT] = '{
      '{32'h00000037, MU, OPT_LUI, F_U},   '{32'h00000017, MU, OPT_AUIPC, F_U},
      '{32'h0000006f, MU, OPT_JAL, F_J},   '{32'h00000067, MI, OPT_JALR, F_I},
      '{32'h00000063, MI, OPT_BEQ, F_B},   '{32'h00001063, MI, OPT_BNE, F_B},
      '{32'h00004063, MI, OPT_BLT, F_B},   '{32'h00005063, MI, OPT_BGE, F_B},
      '{32'h00006063, MI, OPT_BLTU, F_B},  '{32'h00007063, MI, OPT_BGEU, F_B},
      '{32'h00000003, MI, OPT_LB, F_I},    '{32'h00001003, MI, OPT_LH, F_I},
      '{32'h00002003, MI, OPT_LW, F_I},    '{32'h00004003, MI, OPT_LBU, F_I},
      '{32'h00005003, MI, OPT_LHU, F_I},
      '{32'h00000023, MI, OPT_SB, F_S},    '{32'h00001023, MI, OPT_SH, F_S},
      '{32'h00002023, MI, OPT_SW, F_S},
      '{32'h00000013, MI, OPT_ADDI, F_I},  '{32'h00002013, MI, OPT_SLTI, F_I},
      '{32'h00003013, MI, OPT_SLTIU, F_I}, '{32'h00004013, MI, OPT_XORI, F_I},
      '{32'h00006013, MI, OPT_ORI, F_I},   '{32'h00007013, MI, OPT_ANDI, F_I},
      '{32'h00001013, MR, OPT_SLLI, F_SH}, '{32'h00005013, MR, OPT_SRLI, F_SH},
      '{32'h40005013, MR, OPT_SRAI, F_SH},
      '{32'h00000033, MR, OPT_ADD, F_R},   '{32'h40000033, MR, OPT_SUB, F_R},
      '{32'h00001033, MR, OPT_SLL, F_R},   '{32'h00002033, MR, OPT_SLT, F_R},
      '{32'h00003033, MR, OPT_SLTU, F_R},  '{32'h00004033, MR, OPT_XOR, F_R},
      '{32'h00005033, MR, OPT_SRL, F_R},   '{32'h40005033, MR, OPT_SRA, F_R},
      '{32'h00006033, MR, OPT_OR, F_R},    '{32'h00007033, MR, OPT_AND, F_R},
      '{32'h02000033, MR, OPT_MUL, F_R},   '{32'h02001033, MR, OPT_MULH, F_R},
      '{32'h02002033, MR, OPT_MULHSU, F_R},'{32'h02003033, MR, OPT_MULHU, F_R},
      '{32'h02004033, MR, OPT_DIV, F_R},   '{32'h02005033, MR, OPT_DIVU, F_R},
      '{32'h02006033, MR, OPT_REM, F_R},   '{32'h02007033, MR, OPT_REMU, F_R}
   };

   logic [31:0] prog [8] = '{32'h123452b7, 32'h00001317, 32'h008000ef, 32'hfe208ee3,
                             32'h00412383, 32'hfe712c23, 32'h4034d413, 32'h40c58533};

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, out_ready;
   logic [31:0] in_pc, in_inst;
   obs_t        obs [2];

   int n_tests = 0, n_fail = 0, n_acc = 0, n_hs = 0;
   bit chk_en = 1'b0, m_acc = 1'b0;

   logic [63:0] mq [$];
   logic [31:0] sb [$];
   bit          mv = 1'b0, mb_set = 1'b0;
   logic [31:0] mb_pc = '0, mb_inst = '0;

   always #5 clk = ~clk;

   function automatic logic [31:0] rf(input logic [4:0] a);
      return 32'h5A00_0000 ^ ({27'b0, a} << 8) ^ {27'b0, a};
   endfunction

   for (genvar g = 0; g < 2; g++) begin : gd
      logic irdy, ov, re1, re2, we, ill;
      logic [4:0] ra1, ra2, wa, sh;
      logic [31:0] pc, rd1, rd2, imm;
      logic [6:0] opc;
      logic [OPT_W-1:0] opt;
      id_stage_q #(.IQ_DEPTH(D), .ENABLE_M(g == 1)) u_dut (
         .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(irdy),
         .in_pc_i(in_pc), .in_inst_i(in_inst), .re1_o(re1), .re2_o(re2),
         .raddr1_o(ra1), .raddr2_o(ra2), .rdata1_i(rf(ra1)), .rdata2_i(rf(ra2)),
         .out_valid_o(ov), .out_ready_i(out_ready), .pc_o(pc), .opcode_o(opc), .opt_o(opt),
         .rdata1_o(rd1), .rdata2_o(rd2), .we_o(we), .waddr_o(wa), .imm_o(imm),
         .shamt_o(sh), .illegal_o(ill));
      assign obs[g] = '{irdy, ov, re1, re2, ra1, ra2, pc, opc, opt, rd1, rd2, we, wa, imm, sh, ill};
   end

   task automatic chk(input string nm, input int g, input logic [31:0] a, input logic [31:0] e);
      n_tests++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s dut%0d @%0t: got %h want %h", nm, g, $time, a, e);
      end
   endtask

   function automatic void mdec(input logic [31:0] w, input bit en_m,
                                output bit ok, output opt_e op, output fmt_e f);
      ok = 1'b0; op = OPT_NOP; f = F_R;
      for (int k = 0; k < NT; k++)
         if ((w & tbl[k].mask) == tbl[k].match && (tbl[k].opt < OPT_MUL || en_m)) begin
            ok = 1'b1; op = tbl[k].opt; f = tbl[k].fmt;
         end
   endfunction

   function automatic logic [31:0] imm_of(input logic [31:0] w, input fmt_e f);
      logic signed [31:0] s = $signed(w);
      case (f)
         F_U: return w & 32'hFFFF_F000;
         F_I: return 32'(s >>> 20);
         F_S: return (32'(s >>> 20) & ~32'h1f) | {27'b0, w[11:7]};
         F_B: return (32'(s >>> 19) & ~32'hFFF) | {20'b0, w[7], w[30:25], w[11:8], 1'b0};
         F_J: return (32'(s >>> 11) & ~32'hF_FFFF) | {12'b0, w[19:12], w[20], w[30:21], 1'b0};
         default: return 32'h0;
      endcase
   endfunction

   function automatic obs_t expect_obs(input int g);
      obs_t e; bit ok; opt_e op; fmt_e f; logic [31:0] w;
      e = '0;
      e.irdy = !rst && (mq.size() < D);
      e.ov   = mv;
      if (mq.size() > 0) begin
         w = mq[0][31:0];
         mdec(w, g == 1, ok, op, f);
         e.ra1 = w[19:15]; e.ra2 = w[24:20];
         e.re1 = ok && f != F_U && f != F_J;
         e.re2 = ok && (f == F_B || f == F_S || f == F_R);
      end
      if (mb_set) begin
         w = mb_inst;
         mdec(w, g == 1, ok, op, f);
         e.pc = mb_pc; e.rd1 = rf(w[19:15]); e.rd2 = rf(w[24:20]); e.ill = !ok;
         if (ok) begin
            e.opc = w[6:0]; e.opt = op; e.imm = imm_of(w, f);
            e.sh  = (f == F_SH) ? w[24:20] : 5'd0;
            e.wa  = (f == F_B || f == F_S) ? 5'd0 : w[11:7];
            e.we  = (e.wa != 5'd0);
         end
      end
      return e;
   endfunction

   // Model and output scoreboard advance on each rising edge.
   initial forever begin
      logic [63:0] ent;
      bit hv, rdy, adv, psh;
      @(posedge clk);
      m_acc = 1'b0;
      if (!rst && obs[0].ov && out_ready) begin
         n_hs++;
         if (sb.size() == 0) chk("sb_extra", 0, obs[0].pc, 32'hFFFF_FFFF);
         else chk("sb_pc", 0, obs[0].pc, sb.pop_front());
      end
      if (rst) begin
         mq.delete(); sb.delete(); mv = 1'b0; mb_set = 1'b0;
      end else if (flush) begin
         mq.delete(); sb.delete(); mv = 1'b0;
      end else begin
         hv  = mq.size() > 0;
         rdy = mq.size() < D;
         adv = hv && (!mv || out_ready);
         psh = in_valid && rdy;
         if (adv) begin
            ent = mq.pop_front();
            mb_pc = ent[63:32]; mb_inst = ent[31:0]; mb_set = 1'b1; mv = 1'b1;
         end else if (mv && out_ready) mv = 1'b0;
         if (psh) begin
            mq.push_back({in_pc, in_inst}); sb.push_back(in_pc);
            m_acc = 1'b1; n_acc++;
         end
      end
   end

   initial forever begin
      obs_t e, a;
      @(negedge clk);
      if (chk_en)
         for (int g = 0; g < 2; g++) begin
            e = expect_obs(g); a = obs[g];
            chk("in_ready", g, a.irdy, e.irdy); chk("out_valid", g, a.ov, e.ov);
            chk("re1", g, a.re1, e.re1);         chk("re2", g, a.re2, e.re2);
            chk("raddr1", g, a.ra1, e.ra1);      chk("raddr2", g, a.ra2, e.ra2);
            chk("pc", g, a.pc, e.pc);            chk("opcode", g, a.opc, e.opc);
            chk("opt", g, a.opt, e.opt);         chk("rdata1", g, a.rd1, e.rd1);
            chk("rdata2", g, a.rd2, e.rd2);      chk("we", g, a.we, e.we);
            chk("waddr", g, a.wa, e.wa);         chk("imm", g, a.imm, e.imm);
            chk("shamt", g, a.sh, e.sh);         chk("illegal", g, a.ill, e.ill);
         end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   initial begin
      int base, k, cyc;
      logic [31:0] pc;
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_pc = '0; in_inst = '0;
      step(); chk_en = 1'b1; step();
      chk("rst_ov", 0, obs[0].ov, 0); chk("rst_opt", 0, obs[0].opt, OPT_NOP);
      chk("rst_pc", 0, obs[0].pc, 0); chk("rst_rdy", 0, obs[0].irdy, 0);

      // Reset mid-stream with three queued words
      rst = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin in_pc = 32'h10 + 4*i; in_inst = prog[i]; step(); end
      in_valid = 1'b0;
      chk("pre_rst_ov", 0, obs[0].ov, 1);
      rst = 1'b1; #1;
      chk("rst_mid_rdy", 0, obs[0].irdy, 0);
      step(); rst = 1'b0; #1;
      chk("post_rst_ov", 0, obs[0].ov, 0); chk("post_rst_rdy", 0, obs[0].irdy, 1);

      // Single addi, then back-to-back stream
      out_ready = 1'b1; in_valid = 1'b1; in_pc = 32'h100; in_inst = 32'h00500093;
      step(); in_valid = 1'b0; step();
      chk("addi_ov", 0, obs[0].ov, 1);   chk("addi_opt", 0, obs[0].opt, OPT_ADDI);
      chk("addi_imm", 0, obs[0].imm, 5); chk("addi_waddr", 0, obs[0].wa, 1);
      chk("addi_we", 0, obs[0].we, 1);   chk("addi_pc", 0, obs[0].pc, 32'h100);
      base = n_hs; in_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin in_pc = 32'h200 + 4*i; in_inst = prog[i]; step(); end
      in_valid = 1'b0;
      repeat (3) step();
      chk("b2b_hs", 0, n_hs - base, 9);

      // Backpressure fill, then drain
      out_ready = 1'b0; in_valid = 1'b1; base = n_acc; pc = 32'h300; k = n_hs;
      for (int i = 0; i < 10; i++) begin
         in_pc = pc; in_inst = prog[i % 8]; step();
         if (m_acc) pc += 4;
      end
      chk("fill_acc", 0, n_acc - base, D + 1); chk("fill_rdy", 0, obs[0].irdy, 0);
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (8) step();
      chk("drain_hs", 0, n_hs - k, D + 1); chk("drain_sb", 0, sb.size(), 0);

      // Flush with full queue, valid bundle and a same-cycle offer
      out_ready = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin in_pc = 32'h380 + 4*i; in_inst = prog[i]; step(); end
      flush = 1'b1; step(); flush = 1'b0;
      chk("flush_ov", 0, obs[0].ov, 0); chk("flush_rdy", 0, obs[0].irdy, 1);
      in_pc = 32'h400; in_inst = prog[6]; step();
      in_valid = 1'b0; out_ready = 1'b1; step();
      chk("post_flush_ov", 0, obs[0].ov, 1); chk("post_flush_pc", 0, obs[0].pc, 32'h400);

      // M-extension and illegal encodings
      in_valid = 1'b1; in_pc = 32'h500; in_inst = 32'h02208033; step();
      in_pc = 32'h504; in_inst = 32'h022081b3; step();
      chk("mul0_ill_m0", 0, obs[0].ill, 1);  chk("mul0_opt_m0", 0, obs[0].opt, OPT_NOP);
      chk("mul0_we_m0", 0, obs[0].we, 0);    chk("mul0_ill_m1", 1, obs[1].ill, 0);
      chk("mul0_opt_m1", 1, obs[1].opt, OPT_MUL); chk("mul0_we_m1", 1, obs[1].we, 0);
      in_pc = 32'h508; in_inst = 32'hFFFFFFFF; step();
      chk("mul3_we_m1", 1, obs[1].we, 1); chk("mul3_wa_m1", 1, obs[1].wa, 3);
      chk("mul3_ill_m0", 0, obs[0].ill, 1);
      in_pc = 32'h50c; in_inst = 32'h40001033; step();
      in_valid = 1'b0;
      repeat (3) step();

      // Pointer wrap with random backpressure
      in_valid = 1'b1; k = 0; cyc = 0;
      while (k < 3*D && cyc < 300) begin
         in_pc = 32'h600 + 4*k; in_inst = prog[k % 8]; out_ready = 1'($urandom_range(0, 1));
         step(); cyc++;
         if (m_acc) k++;
      end
      chk("wrap_acc", 0, k, 3*D);
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (8) step();
      chk("wrap_sb", 0, sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
